// File: rtl/frac_baud_gen.sv
// Fractional-N baud tick generator: oversample, bit-rate and mid-bit ticks.
// Average oversample period is max(div_int,2) + div_frac/2^FRAC_W clk cycles.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            count enable; low freezes all phase state
//   restart       realign phase (clears counters and accumulator)
//   cfg_load      capture div_int/div_frac/ovs_ratio, then realign phase
//   div_int       integer oversample period in clk cycles
//   div_frac      fractional period in units of 2^-FRAC_W cycles
//   ovs_ratio     oversample ticks per bit
//   os_tick       one-cycle oversample tick
//   bit_tick      one-cycle bit-period tick
//   mid_tick      one-cycle mid-bit sample tick
//   bit_cnt       32-bit bit_tick count (only with FRAC_BAUD_BIT_CNT_EN)
//
// Optional build macro FRAC_BAUD_BIT_CNT_EN adds the bit_cnt output.

module frac_baud_gen #(
    parameter int unsigned      CNT_W   = 16,
    parameter int unsigned      FRAC_W  = 8,
    parameter int unsigned      OVS_W   = 5,
    parameter logic [CNT_W-1:0] RST_DIV = 16'd868,
    parameter logic [OVS_W-1:0] RST_OVS = 5'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_load,
    input  logic [CNT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic [OVS_W-1:0]  ovs_ratio,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick
`ifdef FRAC_BAUD_BIT_CNT_EN
    ,
    output logic [31:0]       bit_cnt
`endif
);

    logic [CNT_W-1:0]  a_int;
    logic [FRAC_W-1:0] a_frac;
    logic [OVS_W-1:0]  a_ovs;

    logic [CNT_W-1:0]  cnt;
    logic              ext;
    logic [FRAC_W-1:0] acc;
    logic [OVS_W-1:0]  ocnt;

    logic [CNT_W-1:0]  ei;
    logic [OVS_W-1:0]  eo;
    logic [OVS_W-1:0]  bit_pt;
    logic [OVS_W-1:0]  mid_pt;
    logic              wrap;
    logic              bit_hit;
    logic              realign;
    logic [FRAC_W:0]   acc_sum;

    always_comb begin
        ei      = (a_int < CNT_W'(2)) ? CNT_W'(2) : a_int;
        eo      = (a_ovs == '0) ? OVS_W'(1) : a_ovs;
        bit_pt  = eo - OVS_W'(1);
        // Unused when eo==1; that case is handled explicitly below.
        mid_pt  = (eo >> 1) - OVS_W'(1);
        // Period is ei+ext, so the last count is ei-1+ext (ei>=2, no underflow).
        wrap    = ext ? (cnt == ei) : (cnt == ei - CNT_W'(1));
        bit_hit = (ocnt == bit_pt);
        realign = cfg_load | restart;
        acc_sum = {1'b0, acc} + {1'b0, a_frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_int    <= RST_DIV;
            a_frac   <= '0;
            a_ovs    <= RST_OVS;
            cnt      <= '0;
            ext      <= 1'b0;
            acc      <= '0;
            ocnt     <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            if (cfg_load) begin
                a_int  <= div_int;
                a_frac <= div_frac;
                a_ovs  <= ovs_ratio;
            end
            if (realign) begin
                cnt      <= '0;
                ext      <= 1'b0;
                acc      <= '0;
                ocnt     <= '0;
                os_tick  <= 1'b0;
                bit_tick <= 1'b0;
                mid_tick <= 1'b0;
            end else if (en && wrap) begin
                cnt        <= '0;
                // Accumulator carry stretches the next period by one cycle.
                {ext, acc} <= acc_sum;
                ocnt       <= bit_hit ? '0 : ocnt + OVS_W'(1);
                os_tick    <= 1'b1;
                bit_tick   <= bit_hit;
                mid_tick   <= (eo == OVS_W'(1)) || (ocnt == mid_pt);
            end else begin
                if (en) begin
                    cnt <= cnt + CNT_W'(1);
                end
                os_tick  <= 1'b0;
                bit_tick <= 1'b0;
                mid_tick <= 1'b0;
            end
        end
    end

`ifdef FRAC_BAUD_BIT_CNT_EN
    // Cleared by reset and reconfiguration, but survives a plain restart.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            bit_cnt <= '0;
        end else if (!restart && en && wrap && bit_hit) begin
            bit_cnt <= bit_cnt + 32'd1;
        end
    end
`else
    // bit_tick counter not built in this configuration.
`endif

endmodule
